// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel, W-bit registered multiplexer with per-channel
// valid/ready handshakes. It picks a requesting channel by itself, either
// round-robin from a rotating pointer or fixed priority (lowest index wins).
// The winning word is captured in a single output register. That register
// can drain and refill on the same edge, so a continuous stream has no bubbles.

module mux_rr_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SELW = $clog2(N);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic            load_en;
  logic            xfer;
  logic [SELW:0]   rr_sum;
  logic [SELW-1:0] rr_idx;
  logic [W-1:0]    chan [N];

  // Split the flat input bus into per-channel words so the winner can be picked by index
  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan[i] = in_data[i*W +: W];
    end
  end

  assign load_en = !out_valid || out_ready;

  // Arbitration: the scans run from the lowest priority to the highest, so the last hit wins
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SELW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        rr_sum = {1'b0, ptr} + (SELW+1)'(k);
        if (rr_sum >= (SELW+1)'(N)) begin
          rr_sum = rr_sum - (SELW+1)'(N);
        end
        rr_idx = rr_sum[SELW-1:0];
        if (in_valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant     = rr_idx;
        end
      end
    end
  end

  // Only the granted channel sees ready, and only when the output register can take a word
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_vld) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign xfer = rst_n && load_en && grant_vld;

  // Output register: load on a transfer, empty on a drain without refill, hold on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= chan[grant];
      out_sel   <= grant;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner only in round-robin mode, and is kept across mode switches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && !mode) begin
      ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
    end
  end

endmodule
